// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer driving a shared 8-bit ALU for single ops, multi-step shifts and shift-add multiply
module alu_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [2:0] req_cnt,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_in0,
    output logic [7:0] alu_in1,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] CMD_SINGLE = 2'b00;
    localparam logic [1:0] CMD_SHL    = 2'b01;
    localparam logic [1:0] CMD_SHR    = 2'b10;
    localparam logic [1:0] CMD_MUL    = 2'b11;

    localparam logic [3:0] OP_BYPASS = 4'b0000;
    localparam logic [3:0] OP_SHL1   = 4'b0010;
    localparam logic [3:0] OP_SHR1   = 4'b0100;
    localparam logic [3:0] OP_ADD    = 4'b1110;

    logic [1:0] state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic [3:0] op_q, op_d;
    logic       bypass_q, bypass_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] mplier_q, mplier_d;
    logic [2:0] count_q, count_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_zero_q, rsp_zero_d;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

    // SINGLE reuses acc/mcand as its a/b operand latches
    always_comb begin
        alu_opcode = OP_BYPASS;
        alu_in0    = 8'h00;
        alu_in1    = 8'h00;
        if (state_q == ST_EXEC) begin
            alu_in0 = acc_q;
            case (cmd_q)
                CMD_SINGLE: begin
                    alu_opcode = op_q;
                    alu_in1    = mcand_q;
                end
                CMD_SHL: alu_opcode = bypass_q ? OP_BYPASS : OP_SHL1;
                CMD_SHR: alu_opcode = bypass_q ? OP_BYPASS : OP_SHR1;
                default: begin
                    if (mplier_q[0]) begin
                        alu_opcode = OP_ADD;
                        alu_in1    = mcand_q;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        op_d       = op_q;
        bypass_d   = bypass_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        count_d    = count_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_EXEC;
                    cmd_d    = req_cmd;
                    op_d     = req_op;
                    bypass_d = (req_cnt == 3'd0);
                    acc_d    = (req_cmd == CMD_MUL) ? 8'h00 : req_a;
                    mcand_d  = (req_cmd == CMD_SINGLE) ? req_b : req_a;
                    mplier_d = req_b;
                    case (req_cmd)
                        CMD_SINGLE: count_d = 3'd0;
                        CMD_MUL:    count_d = 3'd7;
                        default:    count_d = (req_cnt == 3'd0) ? 3'd0 : req_cnt - 3'd1;
                    endcase
                end
            end
            ST_EXEC: begin
                acc_d = alu_result;
                if (cmd_q == CMD_MUL) begin
                    mcand_d  = {mcand_q[6:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[7:1]};
                end
                if (count_q == 3'd0) begin
                    rsp_data_d = alu_result;
                    rsp_zero_d = alu_zero;
                    state_d    = ST_DONE;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_SINGLE;
            op_q       <= 4'h0;
            bypass_q   <= 1'b0;
            acc_q      <= 8'h00;
            mcand_q    <= 8'h00;
            mplier_q   <= 8'h00;
            count_q    <= 3'd0;
            rsp_data_q <= 8'h00;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            op_q       <= op_d;
            bypass_q   <= bypass_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            count_q    <= count_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural shared ALU
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] req_cnt;
    logic [3:0] alu_opcode;
    logic [7:0] alu_in0;
    logic [7:0] alu_in1;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       busy;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
        .alu_opcode(alu_opcode), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode)
            4'b0000: alu_result = alu_in0;
            4'b0001: alu_result = alu_in0 - alu_in1;
            4'b0010: alu_result = {alu_in0[6:0], 1'b0};
            4'b0011: alu_result = alu_in0 & alu_in1;
            4'b0100: alu_result = {1'b0, alu_in0[7:1]};
            4'b0101: alu_result = alu_in0 | alu_in1;
            4'b0110: alu_result = alu_in0 ^ alu_in1;
            4'b1110: alu_result = alu_in0 + alu_in1;
            default: alu_result = ~alu_in0;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        logic [1:0] cmd;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] cnt;
        logic [7:0] exp_data;
        logic       exp_zero;
        int         exp_lat;
    } vec_t;

    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_cnt   = v.cnt;
    endtask

    // scrambles req_* after acceptance so a design that re-reads them is caught
    task automatic scramble();
        req_valid = 1'b0;
        req_cmd   = ~req_cmd;
        req_op    = 4'h6;
        req_a     = 8'hA5;
        req_b     = 8'h5A;
        req_cnt   = 3'd5;
    endtask

    task automatic wait_rsp(inout int lat);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic issue(input vec_t v, output int lat, output logic [7:0] d, output logic z);
        @(negedge clk);
        drive(v);
        @(negedge clk);
        scramble();
        lat = 1;
        wait_rsp(lat);
        d = rsp_data;
        z = rsp_zero;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int         lat;
    logic [7:0] d;
    logic       z;
    vec_t       hv;
    int         seen;

    initial begin
        vecs[0]  = '{2'b00, 4'b1110, 8'h05, 8'h03, 3'd0, 8'h08, 1'b0, 2};
        vecs[1]  = '{2'b00, 4'b0001, 8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 2};
        vecs[2]  = '{2'b00, 4'b0110, 8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 2};
        vecs[3]  = '{2'b01, 4'b0000, 8'h81, 8'h00, 3'd3, 8'h08, 1'b0, 4};
        vecs[4]  = '{2'b10, 4'b0000, 8'h81, 8'h00, 3'd0, 8'h81, 1'b0, 2};
        vecs[5]  = '{2'b10, 4'b0000, 8'h80, 8'h00, 3'd7, 8'h01, 1'b0, 8};
        vecs[6]  = '{2'b01, 4'b0000, 8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 8};
        vecs[7]  = '{2'b10, 4'b0000, 8'h01, 8'h00, 3'd1, 8'h00, 1'b1, 2};
        vecs[8]  = '{2'b11, 4'b0000, 8'h0D, 8'h0B, 3'd0, 8'h8F, 1'b0, 9};
        vecs[9]  = '{2'b11, 4'b0000, 8'h10, 8'h10, 3'd0, 8'h00, 1'b1, 9};
        vecs[10] = '{2'b11, 4'b0000, 8'hFF, 8'hFF, 3'd0, 8'h01, 1'b0, 9};
        vecs[11] = '{2'b11, 4'b0000, 8'h07, 8'h00, 3'd0, 8'h00, 1'b1, 9};

        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        drive(vecs[8]);
        repeat (3) @(negedge clk);
        check("reset_state", {busy, req_ready, rsp_valid, rsp_data, rsp_zero}, {3'b010, 8'h00, 1'b0});
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, req_ready, alu_opcode, alu_in0, alu_in1}, {2'b01, 20'h0});

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i], lat, d, z);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_zero", i), z, vecs[i].exp_zero);
            release_rsp();
            check($sformatf("vec%0d_idle", i), {req_ready, busy, rsp_valid}, 3'b100);
        end

        // shift sequencing: opcode and operand per EXEC cycle
        @(negedge clk);
        drive(vecs[3]);
        @(negedge clk);
        scramble();
        check("shl_exec1", {alu_opcode, alu_in0}, {4'b0010, 8'h81});
        @(negedge clk);
        check("shl_exec2", {alu_opcode, alu_in0}, {4'b0010, 8'h02});
        @(negedge clk);
        check("shl_exec3", {alu_opcode, alu_in0}, {4'b0010, 8'h04});
        @(negedge clk);
        check("shl_done", {rsp_valid, rsp_data, alu_opcode}, {1'b1, 8'h08, 4'b0000});
        release_rsp();
        @(negedge clk);
        drive(vecs[4]);
        @(negedge clk);
        scramble();
        check("shr0_bypass", {alu_opcode, alu_in0}, {4'b0000, 8'h81});
        @(negedge clk);
        check("shr0_done", {rsp_valid, rsp_data}, {1'b1, 8'h81});
        release_rsp();

        // backpressure hold
        hv = '{2'b00, 4'b0101, 8'h30, 8'h05, 3'd0, 8'h35, 1'b0, 2};
        issue(hv, lat, d, z);
        check("bp_first", {lat[7:0], d}, {8'd2, 8'h35});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {rsp_valid, req_ready, busy, rsp_data}, {3'b101, 8'h35});
        end
        release_rsp();
        check("bp_release", {req_ready, rsp_valid}, 2'b10);

        // reset in the 4th EXEC cycle of a multiply
        @(negedge clk);
        drive(vecs[8]);
        @(negedge clk);
        scramble();
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_reset", {busy, req_ready, rsp_valid, rsp_data, rsp_zero}, {3'b010, 8'h00, 1'b0});
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
        issue(vecs[0], lat, d, z);
        check("post_reset_single", {lat[7:0], d, 7'b0, z}, {8'd2, 8'h08, 8'h00});
        release_rsp();

        // back-to-back with rsp_ready and req_valid held high
        @(negedge clk);
        rsp_ready = 1'b1;
        drive('{2'b00, 4'b1110, 8'h10, 8'h20, 3'd0, 8'h30, 1'b0, 2});
        @(negedge clk);
        lat = 1;
        wait_rsp(lat);
        check("b2b_first", {lat[7:0], rsp_data}, {8'd2, 8'h30});
        drive('{2'b00, 4'b0110, 8'h0F, 8'h3C, 3'd0, 8'h33, 1'b0, 2});
        @(negedge clk);
        check("b2b_idle_gap", {req_ready, rsp_valid}, 2'b10);
        @(negedge clk);
        check("b2b_second_accepted", {busy, req_ready}, 2'b10);
        scramble();
        lat = 1;
        wait_rsp(lat);
        check("b2b_second", {lat[7:0], rsp_data}, {8'd2, 8'h33});
        @(negedge clk);
        check("b2b_one_cycle_done", {req_ready, rsp_valid}, 2'b10);
        rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port req_valid  in  1  command request valid.
REQ-004 SHALL have port req_ready  out  1  block can accept a command.
REQ-005 SHALL have port req_cmd  in  2  00=SINGLE, 01=SHL_N, 10=SHR_N, 11=MUL.
REQ-006 SHALL have port req_op  in  4  ALU opcode, used only for SINGLE.
REQ-007 SHALL have ports req_a, req_b  in  8 each  operands; MUL: a=multiplicand, b=multiplier.
REQ-008 SHALL have port req_cnt  in  3  shift count for SHL_N/SHR_N.
REQ-009 SHALL have port alu_opcode  out  4  opcode driven to the shared 8-bit ALU.
REQ-010 SHALL have ports alu_in0, alu_in1  out  8 each  ALU operands.
REQ-011 SHALL have ports alu_result  in  8, alu_zero  in  1  ALU combinational outputs.
REQ-012 SHALL have ports rsp_valid  out  1, rsp_ready  in  1  response handshake.
REQ-013 SHALL have ports rsp_data  out  8, rsp_zero  out  1  result and zero flag.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, EXEC, DONE; req_ready=1 only in IDLE.
REQ-016 SHALL accept a command on a clk edge with req_valid & req_ready, latch all req_* fields, and enter EXEC.
REQ-017 SHALL run k EXEC cycles: SINGLE k=1; SHL_N/SHR_N k=max(req_cnt,1); MUL k=8.
REQ-018 SINGLE SHALL drive alu_opcode=req_op, alu_in0=a, alu_in1=b for its EXEC cycle.
REQ-019 SHL_N SHALL drive opcode 0010, alu_in0=acc, acc<=alu_result each cycle; SHR_N likewise with opcode 0100; acc initialised to a.
REQ-020 req_cnt=0 SHALL execute one EXEC cycle with opcode 0000 (bypass), result = a.
REQ-021 MUL SHALL keep acc (init 0), mcand (init a), mplier (init b); per EXEC cycle: if mplier[0]=1 drive opcode 1110, in0=acc, in1=mcand, else opcode 0000, in0=acc; acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1 (local registers, not the ALU).
REQ-022 MUL result SHALL be low 8 bits of a*b; overflow silently discarded.
REQ-023 On the last EXEC cycle SHALL register rsp_data<=alu_result, rsp_zero<=alu_zero, and enter DONE.
REQ-024 For acceptance at edge T, rsp_valid SHALL rise at edge T+k+1 (SINGLE: T+2).
REQ-025 In DONE, rsp_valid=1 and rsp_data/rsp_zero SHALL hold stable until the edge with rsp_ready=1, then go to IDLE.
REQ-026 rsp_ready may already be high on DONE entry; the block SHALL then leave DONE after exactly one cycle.
REQ-027 A new command SHALL not be accepted in the DONE cycle; earliest acceptance is the first IDLE cycle (no overlap).
REQ-028 In IDLE and DONE SHALL drive alu_opcode=0000, alu_in0=0, alu_in1=0.
REQ-029 req_* changes after acceptance SHALL not affect the running command.
REQ-030 rsp_zero SHALL equal (rsp_data==0) for every completed command.

Reset
REQ-031 reset_n=0 at an edge SHALL force IDLE, req_ready=1 the following cycle, rsp_valid=0, busy=0, rsp_data=0x00, rsp_zero=0, acc/mcand/mplier/count=0.
REQ-032 Reset during EXEC or DONE SHALL discard the command with no response produced.
REQ-033 req_valid during reset SHALL be ignored; no command accepted while reset_n=0.

Verification
REQ-034 SINGLE op=1110, a=0x05, b=0x03, accepted at T -> rsp_valid at T+2, rsp_data=0x08, rsp_zero=0.
REQ-035 SHL_N a=0x81, cnt=3 -> three EXEC cycles, opcode 0010 each, rsp_data=0x08 at T+4; SHR_N a=0x81, cnt=0 -> opcode 0000, rsp_data=0x81 at T+2.
REQ-036 MUL a=0x0D, b=0x0B -> rsp_data=0x8F at T+9; MUL a=0x10, b=0x10 -> rsp_data=0x00, rsp_zero=1.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stable, req_ready=0, busy=1; IDLE one edge after rsp_ready=1.
REQ-038 Reset asserted in 4th EXEC cycle of MUL -> next cycle IDLE, rsp_valid never asserts, new SINGLE then completes normally.
REQ-039 Back-to-back: rsp_ready held 1, req_valid held 1 with two SINGLE commands -> second accepted in first IDLE cycle after DONE, both results correct and in order.
